medidor_distancia: RTL and testbench

MEDIDOR_DISTANCIA -- requirements
Module: medidor_distancia

---
 rtl/medidor_pkg.sv | 24 ++
 rtl/sincronizador_2ff.sv | 18 +
 rtl/medidor_distancia.sv | 128 ++++++++++++
 tb/tb_medidor_distancia.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/medidor_pkg.sv
// Shared definitions for the ultrasonic distance meter: state encoding,
// default timing parameters and a counter-width helper.
package medidor_pkg;

   typedef enum logic [2:0] {
      REPOUSO  = 3'd0,
      DISPARO  = 3'd1,
      ESPERA   = 3'd2,
      CONTAGEM = 3'd3,
      FIM      = 3'd4
   } estado_t;

   // Defaults assume a 50 MHz clk.
   localparam int N_PADRAO              = 12;
   localparam int TRIG_CICLOS_PADRAO    = 500;
   localparam int CICLOS_CM_PADRAO      = 2941;
   localparam int TIMEOUT_CICLOS_PADRAO = 1500000;

   // Counter width for a terminal value; never below one bit.
   function automatic int largura(input int terminal);
      return (terminal < 2) ? 1 : $clog2(terminal);
   endfunction

endpackage

// File: rtl/sincronizador_2ff.sv
// Two-flop synchronizer for a single asynchronous input line.
module sincronizador_2ff (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic [1:0] ff;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) ff <= 2'b00;
      else       ff <= {ff[0], d};
   end

   assign q = ff[1];

endmodule

// File: rtl/medidor_distancia.sv
// Ultrasonic range meter: fires a trigger pulse, times the echo pulse and
// reports whole centimetres, or full scale with timeout when no echo ends.
module medidor_distancia
   import medidor_pkg::*;
#(
   parameter int N              = N_PADRAO,
   parameter int TRIG_CICLOS    = TRIG_CICLOS_PADRAO,
   parameter int CICLOS_CM      = CICLOS_CM_PADRAO,
   parameter int TIMEOUT_CICLOS = TIMEOUT_CICLOS_PADRAO
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         medir,
   input  logic         echo,
   output logic         trigger,
   output logic [N-1:0] distancia,
   output logic         pronto,
   output logic         timeout,
   output logic         ocupado
);

   localparam int TRIG_W = largura(TRIG_CICLOS);
   localparam int SUB_W  = largura(CICLOS_CM);
   localparam int TMO_W  = largura(TIMEOUT_CICLOS);

   localparam logic [TRIG_W-1:0] TRIG_FIM = TRIG_W'(TRIG_CICLOS - 1);
   localparam logic [SUB_W-1:0]  SUB_FIM  = SUB_W'(CICLOS_CM - 1);
   localparam logic [TMO_W-1:0]  TMO_FIM  = TMO_W'(TIMEOUT_CICLOS - 1);

   estado_t           estado;
   logic              echo_s;
   logic              echo_ant;
   logic [TRIG_W-1:0] trig_cnt;
   logic [SUB_W-1:0]  sub_cnt;
   logic [N-1:0]      cm_cnt;
   logic [TMO_W-1:0]  tmo_cnt;

   sincronizador_2ff u_sinc_echo (
      .clk   (clk),
      .reset (reset),
      .d     (echo),
      .q     (echo_s)
   );

   assign ocupado = (estado != REPOUSO);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         estado    <= REPOUSO;
         echo_ant  <= 1'b0;
         trigger   <= 1'b0;
         pronto    <= 1'b0;
         timeout   <= 1'b0;
         distancia <= '0;
         trig_cnt  <= '0;
         sub_cnt   <= '0;
         cm_cnt    <= '0;
         tmo_cnt   <= '0;
      end else begin
         echo_ant <= echo_s;
         pronto   <= 1'b0;
         case (estado)
            REPOUSO: begin
               if (medir) begin
                  estado   <= DISPARO;
                  trigger  <= 1'b1;
                  trig_cnt <= '0;
               end
            end
            DISPARO: begin
               if (trig_cnt == TRIG_FIM) begin
                  estado  <= ESPERA;
                  trigger <= 1'b0;
                  tmo_cnt <= '0;
               end else begin
                  trig_cnt <= trig_cnt + 1'b1;
               end
            end
            ESPERA: begin
               if (tmo_cnt == TMO_FIM) begin
                  estado    <= FIM;
                  distancia <= '1;
                  timeout   <= 1'b1;
                  pronto    <= 1'b1;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
                  // Only a fresh rise counts; an echo already high stays ignored.
                  if (echo_s && !echo_ant) begin
                     estado  <= CONTAGEM;
                     sub_cnt <= SUB_W'(1);
                     cm_cnt  <= '0;
                  end
               end
            end
            CONTAGEM: begin
               // Expiry is checked first so it wins over a coincident echo fall.
               if (tmo_cnt == TMO_FIM) begin
                  estado    <= FIM;
                  distancia <= '1;
                  timeout   <= 1'b1;
                  pronto    <= 1'b1;
               end else if (!echo_s) begin
                  estado    <= FIM;
                  distancia <= cm_cnt;
                  timeout   <= 1'b0;
                  pronto    <= 1'b1;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
                  if (sub_cnt == SUB_FIM) begin
                     sub_cnt <= '0;
                     if (cm_cnt != '1) cm_cnt <= cm_cnt + 1'b1;
                  end else begin
                     sub_cnt <= sub_cnt + 1'b1;
                  end
               end
            end
            FIM: begin
               estado <= REPOUSO;
            end
            default: begin
               estado  <= REPOUSO;
               trigger <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_medidor_distancia.sv
// Directed checks of the distance meter with short timing parameters; a
// second instance with N=4 covers counter saturation.
module tb_medidor_distancia;

   logic        clk = 1'b0;
   logic        reset;
   logic        medir, echo, medir2, echo2;
   logic        trigger, pronto, timeout, ocupado;
   logic        trigger2, pronto2, timeout2, ocupado2;
   logic [11:0] distancia;
   logic [3:0]  distancia2;

   int n_tests = 0;
   int n_fail  = 0;
   int pronto_n = 0;

   always #5 clk = ~clk;

   medidor_distancia #(.N(12), .TRIG_CICLOS(10), .CICLOS_CM(100), .TIMEOUT_CICLOS(5000)) dut (
      .clk(clk), .reset(reset), .medir(medir), .echo(echo), .trigger(trigger),
      .distancia(distancia), .pronto(pronto), .timeout(timeout), .ocupado(ocupado)
   );

   medidor_distancia #(.N(4), .TRIG_CICLOS(10), .CICLOS_CM(100), .TIMEOUT_CICLOS(10000)) dut_sat (
      .clk(clk), .reset(reset), .medir(medir2), .echo(echo2), .trigger(trigger2),
      .distancia(distancia2), .pronto(pronto2), .timeout(timeout2), .ocupado(ocupado2)
   );

   always @(posedge clk) if (pronto === 1'b1) pronto_n <= pronto_n + 1;

   function automatic logic get_trig(input int w);
      return (w == 0) ? trigger : trigger2;
   endfunction
   function automatic logic get_ocu(input int w);
      return (w == 0) ? ocupado : ocupado2;
   endfunction
   function automatic logic get_pronto(input int w);
      return (w == 0) ? pronto : pronto2;
   endfunction

   task automatic set_medir(input int w, input logic v);
      if (w == 0) medir = v; else medir2 = v;
   endtask
   task automatic set_echo(input int w, input logic v);
      if (w == 0) echo = v; else echo2 = v;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Pulse medir for one cycle and follow the trigger until it drops.
   task automatic start_meas(input int w, input int extra_at, output int hi,
                             output bit ocu_ok, output bit ok);
      hi = 0; ocu_ok = 1'b1; ok = 1'b0;
      set_medir(w, 1'b1);
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         set_medir(w, 1'b0);
         if (get_ocu(w) !== 1'b1) ocu_ok = 1'b0;
         if (get_trig(w) === 1'b1) begin
            hi++;
            if (hi == extra_at) set_medir(w, 1'b1);
         end else begin
            ok = (hi > 0);
            break;
         end
      end
      set_medir(w, 1'b0);
   endtask

   task automatic echo_pulse(input int w, input int gap, input int width, input int medir_at,
                             output bit ocu_ok);
      ocu_ok = 1'b1;
      repeat (gap) @(negedge clk);
      set_echo(w, 1'b1);
      for (int i = 0; i < width; i++) begin
         @(negedge clk);
         set_medir(w, 1'b0);
         if (get_ocu(w) !== 1'b1) ocu_ok = 1'b0;
         if (i == medir_at) set_medir(w, 1'b1);
      end
      set_medir(w, 1'b0);
      set_echo(w, 1'b0);
   endtask

   task automatic wait_pronto(input int w, input int max, output int n, output bit ok);
      n = 0; ok = 1'b0;
      while (n < max) begin
         @(negedge clk);
         n++;
         if (get_pronto(w) === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   initial begin
      int  hi, n, p0;
      bit  ok, oc;

      reset = 1'b1; medir = 1'b0; echo = 1'b0; medir2 = 1'b0; echo2 = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_trigger", trigger, 0);
      chk("rst_pronto", pronto, 0);
      chk("rst_timeout", timeout, 0);
      chk("rst_distancia", distancia, 0);
      chk("rst_ocupado", ocupado, 0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // Normal measurement: 1050 echo cycles -> 10 cm.
      p0 = pronto_n;
      start_meas(0, 0, hi, oc, ok);
      chk("norm_trig_seen", ok, 1);
      chk("norm_trig_len", hi, 10);
      chk("norm_ocupado", oc, 1);
      echo_pulse(0, 20, 1050, -1, oc);
      wait_pronto(0, 50, n, ok);
      chk("norm_pronto_seen", ok, 1);
      chk("norm_latency", n, 3);
      chk("norm_distancia", distancia, 10);
      chk("norm_timeout", timeout, 0);
      @(negedge clk);
      chk("norm_pronto_one_cycle", pronto, 0);
      repeat (5) @(negedge clk);
      chk("norm_pronto_count", pronto_n - p0, 1);
      chk("norm_idle", ocupado, 0);
      chk("norm_hold", distancia, 10);

      // No echo at all: full-scale timeout after 5000 cycles in ESPERA.
      start_meas(0, 0, hi, oc, ok);
      chk("noecho_trig_seen", ok, 1);
      wait_pronto(0, 6000, n, ok);
      chk("noecho_pronto_seen", ok, 1);
      chk("noecho_latency", n, 5000);
      chk("noecho_distancia", distancia, 4095);
      chk("noecho_timeout", timeout, 1);
      repeat (5) @(negedge clk);

      // Echo stuck high before the measurement must not start counting.
      echo = 1'b1;
      repeat (5) @(negedge clk);
      start_meas(0, 0, hi, oc, ok);
      chk("stuck_trig_seen", ok, 1);
      wait_pronto(0, 6000, n, ok);
      chk("stuck_pronto_seen", ok, 1);
      chk("stuck_latency", n, 5000);
      chk("stuck_distancia", distancia, 4095);
      chk("stuck_timeout", timeout, 1);
      echo = 1'b0;
      repeat (5) @(negedge clk);

      // medir while busy is ignored; 250 echo cycles -> 2 cm.
      p0 = pronto_n;
      start_meas(0, 3, hi, oc, ok);
      chk("busy_trig_len", hi, 10);
      chk("busy_ocupado_disparo", oc, 1);
      echo_pulse(0, 10, 250, 100, oc);
      chk("busy_ocupado_contagem", oc, 1);
      wait_pronto(0, 50, n, ok);
      chk("busy_pronto_seen", ok, 1);
      chk("busy_distancia", distancia, 2);
      chk("busy_timeout", timeout, 0);
      repeat (30) @(negedge clk);
      chk("busy_pronto_count", pronto_n - p0, 1);
      chk("busy_not_queued", ocupado, 0);

      // Reset in the middle of counting aborts with no pronto.
      p0 = pronto_n;
      start_meas(0, 0, hi, oc, ok);
      echo = 1'b1;
      repeat (50) @(negedge clk);
      reset = 1'b1;
      #1;
      chk("rstmid_trigger", trigger, 0);
      chk("rstmid_distancia", distancia, 0);
      chk("rstmid_ocupado", ocupado, 0);
      chk("rstmid_pronto", pronto, 0);
      echo = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (10) @(negedge clk);
      chk("rstmid_no_pronto", pronto_n - p0, 0);
      chk("rstmid_idle", ocupado, 0);
      start_meas(0, 0, hi, oc, ok);
      chk("rstmid_restart", ok, 1);
      echo_pulse(0, 20, 99, -1, oc);
      wait_pronto(0, 50, n, ok);
      chk("short_pronto_seen", ok, 1);
      chk("short_distancia", distancia, 0);
      chk("short_timeout", timeout, 0);

      // Saturation on the 4-bit instance: 2000 echo cycles -> 15, not 4.
      start_meas(1, 0, hi, oc, ok);
      chk("sat_trig_seen", ok, 1);
      echo_pulse(1, 20, 2000, -1, oc);
      wait_pronto(1, 50, n, ok);
      chk("sat_pronto_seen", ok, 1);
      chk("sat_distancia", distancia2, 15);
      chk("sat_timeout", timeout2, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
